// File: rtl/dino_pkg.sv
// Shared types and default constants for the dino game input path.
package dino_pkg;

  localparam int unsigned TICK_DIV_DEF   = 2048;
  localparam int unsigned HOLD_TICKS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    JUMP     = 2'd1,
    WAIT_REL = 2'd2,
    DUCK     = 2'd3
  } btn_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle strobe every TICK_DIV cycles.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 2048
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TICK_DIV - 2);

  logic [CNT_W-1:0] cnt_q;

  // Counter wraps at TICK_DIV-1; strobe is registered one count early so it
  // is high exactly while the counter holds TICK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      tick  <= (cnt_q == CNT_PRE);
    end
  end

endmodule

// File: rtl/button_input_ctrl.sv
// Paces the button debouncers and turns debounced jump/duck levels into
// game commands (start, short/long jump pulses, duck level).
module button_input_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic game_run,
  input  logic jump_db,
  input  logic duck_db,
  output logic countdown_en,
  output logic start_pulse,
  output logic jump_pulse,
  output logic jump_long,
  output logic duck_out
);

  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

  btn_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              jump_q;
  logic              jump_rise;
  logic              start_d, jpulse_d, jlong_d, duck_d;

  // Shared debouncer pacing strobe.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (countdown_en)
  );

  assign jump_rise = jump_db & ~jump_q;

  // State, hold counter, edge register and registered command outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      jump_q      <= 1'b0;
      start_pulse <= 1'b0;
      jump_pulse  <= 1'b0;
      jump_long   <= 1'b0;
      duck_out    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      jump_q      <= jump_db;
      start_pulse <= start_d;
      jump_pulse  <= jpulse_d;
      jump_long   <= jlong_d;
      duck_out    <= duck_d;
    end
  end

  // Next-state and next-output decode; jump always takes priority over duck.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    start_d  = 1'b0;
    jpulse_d = 1'b0;
    jlong_d  = 1'b0;
    duck_d   = 1'b0;

    if (!game_run) begin
      state_d = IDLE;
      hold_d  = '0;
      start_d = jump_rise;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (jump_rise) begin
            jpulse_d = 1'b1;
            hold_d   = '0;
            state_d  = JUMP;
          end else if (duck_db) begin
            duck_d  = 1'b1;
            state_d = DUCK;
          end
        end

        JUMP: begin
          if (!jump_db) begin
            hold_d  = '0;
            state_d = IDLE;
          end else if (countdown_en) begin
            if (hold_q != HOLD_MAX) begin
              hold_d = hold_q + HOLD_W'(1);
            end
            if (hold_d == HOLD_MAX) begin
              jlong_d = 1'b1;
              state_d = WAIT_REL;
            end
          end
        end

        WAIT_REL: begin
          if (!jump_db) begin
            state_d = IDLE;
          end
        end

        DUCK: begin
          if (jump_rise) begin
            jpulse_d = 1'b1;
            hold_d   = '0;
            state_d  = JUMP;
          end else if (!duck_db) begin
            state_d = IDLE;
          end else begin
            duck_d = 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_input_ctrl.sv
// Directed bench for button_input_ctrl with TICK_DIV=4, HOLD_TICKS=3.
module tb_button_input_ctrl;

  logic clk;
  logic reset;
  logic game_run;
  logic jump_db;
  logic duck_db;
  logic countdown_en;
  logic start_pulse;
  logic jump_pulse;
  logic jump_long;
  logic duck_out;

  int tests;
  int fails;
  int cyc;

  button_input_ctrl #(
    .TICK_DIV   (4),
    .HOLD_TICKS (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .game_run     (game_run),
    .jump_db      (jump_db),
    .duck_db      (duck_db),
    .countdown_en (countdown_en),
    .start_pulse  (start_pulse),
    .jump_pulse   (jump_pulse),
    .jump_long    (jump_long),
    .duck_out     (duck_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic s, input logic j,
                            input logic l, input logic d);
    chk({tag, ".start_pulse"}, start_pulse, s);
    chk({tag, ".jump_pulse"},  jump_pulse,  j);
    chk({tag, ".jump_long"},   jump_long,   l);
    chk({tag, ".duck_out"},    duck_out,    d);
  endtask

  // One clock; sample at the falling edge and check the prescaler phase.
  task automatic step();
    @(negedge clk);
    cyc++;
    chk("countdown_en", countdown_en, (cyc % 4) == 3);
  endtask

  task automatic align();
    while (cyc % 4 != 0) step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    reset    = 1'b1;
    game_run = 1'b0;
    jump_db  = 1'b0;
    duck_db  = 1'b0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    #1;
    check_outs("post_reset", 0, 0, 0, 0);
    chk("post_reset.countdown_en", countdown_en, 1'b0);

    // Prescaler strobes on cycles 3, 7, 11 after release.
    for (int i = 0; i < 12; i++) begin
      step();
      check_outs("prescale", 0, 0, 0, 0);
    end

    // Title screen: rising jump gives start only.
    jump_db = 1'b1;
    step(); check_outs("start", 1, 0, 0, 0);
    step(); check_outs("start_once", 0, 0, 0, 0);
    jump_db = 1'b0;
    step();
    game_run = 1'b1;
    jump_db  = 1'b1;
    step(); check_outs("run_press", 0, 1, 0, 0);
    jump_db = 1'b0;
    step(); check_outs("run_release", 0, 0, 0, 0);

    // Short jump: two ticks held then released, no long jump.
    align();
    jump_db = 1'b1;
    step(); check_outs("short_pulse", 0, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      if (i == 8) jump_db = 1'b0;
      step(); check_outs("short_hold", 0, 0, 0, 0);
    end
    duck_db = 1'b1;
    step(); check_outs("short_idle_duck", 0, 0, 0, 1);
    duck_db = 1'b0;
    step(); check_outs("short_idle_unduck", 0, 0, 0, 0);

    // Long jump: held five ticks, long pulse once on the third tick.
    align();
    jump_db = 1'b1;
    step(); check_outs("long_pulse", 0, 1, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(); check_outs("long_hold", 0, 0, i == 11, 0);
    end
    jump_db = 1'b0;
    step(); check_outs("long_release", 0, 0, 0, 0);
    jump_db = 1'b1;
    step(); check_outs("repress", 0, 1, 0, 0);
    jump_db = 1'b0;
    step(); check_outs("repress_release", 0, 0, 0, 0);

    // Duck, then jump cancels duck in the same cycle.
    duck_db = 1'b1;
    step(); check_outs("duck_on", 0, 0, 0, 1);
    step(); check_outs("duck_hold", 0, 0, 0, 1);
    jump_db = 1'b1;
    step(); check_outs("duck_cancel", 0, 1, 0, 0);
    step(); check_outs("jump_from_duck", 0, 0, 0, 0);
    jump_db = 1'b0;
    duck_db = 1'b0;
    step(); check_outs("duck_jump_release", 0, 0, 0, 0);

    // Jump and duck together from IDLE: jump wins.
    jump_db = 1'b1;
    duck_db = 1'b1;
    step(); check_outs("simul", 0, 1, 0, 0);
    step(); check_outs("simul_after", 0, 0, 0, 0);
    jump_db = 1'b0;
    duck_db = 1'b0;
    step();
    step();

    // game_run drops mid-hold: back to IDLE, no long jump, no start.
    align();
    jump_db = 1'b1;
    step(); check_outs("drop_pulse", 0, 1, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      if (i == 5) game_run = 1'b0;
      step(); check_outs("drop_hold", 0, 0, 0, 0);
    end
    game_run = 1'b1;
    step(); check_outs("drop_resume_held", 0, 0, 0, 0);
    jump_db = 1'b0;
    step();

    // game_run drops mid-duck.
    duck_db = 1'b1;
    step(); check_outs("drop_duck_on", 0, 0, 0, 1);
    game_run = 1'b0;
    step(); check_outs("drop_duck", 0, 0, 0, 0);
    step(); check_outs("drop_duck_stay", 0, 0, 0, 0);
    game_run = 1'b1;
    duck_db  = 1'b0;
    step();

    // Async reset while jump_pulse is high.
    jump_db = 1'b1;
    step(); check_outs("rst_jump_pre", 0, 1, 0, 0);
    reset = 1'b1;
    #1;
    check_outs("rst_jump", 0, 0, 0, 0);
    jump_db = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    #1;
    check_outs("rst_jump_rel", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();

    // Async reset mid-duck, timed while the strobe is high.
    duck_db = 1'b1;
    step(); check_outs("rst_duck_pre", 0, 0, 0, 1);
    while (cyc % 4 != 3) step();
    chk("rst_duck_pre.duck_out", duck_out, 1'b1);
    reset = 1'b1;
    #1;
    check_outs("rst_duck", 0, 0, 0, 0);
    chk("rst_duck.countdown_en", countdown_en, 1'b0);
    duck_db = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 8; i++) begin
      step(); check_outs("rst_duck_after", 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
